// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive path and the future transmit path.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_baud_tick_gen.sv
// Oversampling tick generator; phase restarts whenever the enable is low.
module baud_tick_gen #(
  parameter int unsigned clk_freq     = 12000000,
  parameter int unsigned baud         = 115200,
  parameter int unsigned oversampling = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned TICK_RATE = baud * oversampling;
  localparam int unsigned DIV_RAW   = (clk_freq + TICK_RATE / 2) / TICK_RATE;
  localparam int unsigned DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CW        = $clog2(DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && wrap;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampled bit FSM, valid/ready output register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned TW = $clog2(OVERSAMPLE) + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);

  uart_rx_state_t        state_q, state_d;
  logic [1:0]            sync_q;
  logic                  rxs;
  logic                  tick_en;
  logic                  tick;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [BW-1:0]         bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  deliver;
  logic                  ferr_evt;

  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  assign rxs     = sync_q[1];
  assign tick_en = (state_q != IDLE);

  baud_tick_gen #(
    .clk_freq    (CLK_FREQ),
    .baud        (BAUD),
    .oversampling(OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(tick_en),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    deliver  = 1'b0;
    ferr_evt = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d   = '0;
        bitcnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (tick) begin
          if (tcnt_q == TW'(OVERSAMPLE / 2 - 1)) begin
            tcnt_d  = '0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt_q == TW'(OVERSAMPLE - 1)) begin
            tcnt_d   = '0;
            shreg_d  = {rxs, shreg_q[DATA_BITS-1:1]};
            bitcnt_d = bitcnt_q + BW'(1);
            if (bitcnt_q == BW'(DATA_BITS - 1)) state_d = STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tcnt_q == TW'(OVERSAMPLE - 1)) begin
            tcnt_d = '0;
            if (rxs) begin
              deliver = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_evt = 1'b1;
              state_d  = BREAK;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      BREAK: begin
        tcnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  // A delivery coinciding with a handshake replaces the byte being consumed.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = ferr_evt;
    overrun_d   = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= '1;
      state_q     <= IDLE;
      tcnt_q      <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a byte scoreboard checked on each transfer.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned BIT_CLK = 104;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ  (12000000),
    .BAUD      (115200),
    .OVERSAMPLE(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  int         n_assert  = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  int         ferr_cnt  = 0;
  int         ovr_cnt   = 0;
  int         valid_cyc = 0;
  int         rise_cyc  = 0;
  int         start_cyc = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_prev = 1'b0;
    end else begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_valid) valid_cyc++;
      if (rx_valid && !valid_prev) rise_cyc = cyc;
      valid_prev = rx_valid;
      if (rx_valid && rx_ready) begin
        n_assert++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL sb_underflow: observed byte %0h expected none", rx_data);
        end
        if (exp_q.size() > 0) check("sb_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    step(BIT_CLK);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  int f0, o0, v0;

  initial begin
    step(3);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    step(10);

    // 1: single byte, latency and one-cycle valid with ready high
    f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cyc;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    step(5);
    check("t1_latency_ok", 32'((rise_cyc - start_cyc >= 985) && (rise_cyc - start_cyc <= 997)), 32'd1);
    check("t1_valid_cycles", 32'(valid_cyc - v0), 32'd1);
    check("t1_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t1_no_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2: glitch shorter than half a bit
    f0 = ferr_cnt; v0 = valid_cyc;
    rx = 1'b0;
    step(20);
    rx = 1'b1;
    step(BIT_CLK);
    check("t2_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("t2_no_valid", 32'(valid_cyc - v0), 32'd0);
    check("t2_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 3: bad stop bit followed by a held break
    f0 = ferr_cnt; v0 = valid_cyc;
    send_byte(8'hA3, 1'b0);
    step(2000);
    check("t3_state_break", 32'(dut.state_q), 32'(BREAK));
    check("t3_ferr_once", 32'(ferr_cnt - f0), 32'd1);
    check("t3_no_valid", 32'(valid_cyc - v0), 32'd0);
    rx = 1'b1;
    step(BIT_CLK);
    check("t3_state_idle", 32'(dut.state_q), 32'(IDLE));
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    step(20);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: overrun while the consumer stalls
    o0 = ovr_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    step(5);
    check("t4_valid_held", 32'(rx_valid), 32'd1);
    check("t4_data_kept", 32'(rx_data), 32'h11);
    check("t4_ovr_once", 32'(ovr_cnt - o0), 32'd1);
    rx_ready = 1'b1;
    step(1);
    check("t4_valid_fell", 32'(rx_valid), 32'd0);
    check("t4_data_stays", 32'(rx_data), 32'h11);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5: back-to-back frames with one stop bit
    f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h81, 1'b1);
    step(20);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t5_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t5_no_ovr", 32'(ovr_cnt - o0), 32'd0);

    // 6: reset in the middle of a data bit
    f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cyc;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b1;
    step(BIT_CLK / 2);
    rst_n = 1'b0;
    step(1);
    check("t6_rst_valid", 32'(rx_valid), 32'd0);
    check("t6_rst_data", 32'(rx_data), 32'd0);
    check("t6_rst_ferr", 32'(frame_err), 32'd0);
    check("t6_rst_ovr", 32'(overrun), 32'd0);
    check("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    step(2 * BIT_CLK);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    step(20);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t6_one_delivery", 32'(valid_cyc - v0), 32'd1);
    check("t6_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t6_no_ovr", 32'(ovr_cnt - o0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous 8N1 UART receiver. It turns the serial `rx` pin into bytes on a valid/ready stream and reports framing and overrun errors. It sits on the I/O interface next to the transmit path and is driven by an oversampling baud tick (`OVERSAMPLE` ticks per bit). It is the consuming end of the baud tick generator.

## Interface

Parameters:
- `CLK_FREQ`, default 12000000: system clock frequency in Hz.
- `BAUD`, default 115200: line bit rate.
- `OVERSAMPLE`, default 8: ticks per bit. Must be a power of two, 4 to 16.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx`  in  1  serial line, asynchronous to `clk`; idles high.
- `rx_data`  out  8  received byte; valid while `rx_valid` is high.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts; transfer happens when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse when a bad stop bit is seen.
- `overrun`  out  1  one-cycle pulse when a new byte is dropped.

## Operation

- **Synchronizer:** `rx` passes through 2 flops, reset value 1. All FSM decisions use the synchronized bit `rxs`.
- **Tick source:** `tick_en` = (state != IDLE). While disabled, the tick phase restarts, so tick timing aligns to the detected start edge.
- **Tick counter:** `tcnt` is $clog2(OVERSAMPLE)+1 bits wide. It increments on each tick and clears on every state change.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: `rxs==0` -> START.
  - START: at tick number OVERSAMPLE/2 (mid start bit), sample `rxs`. If 1, it was a false start -> IDLE. If 0 -> DATA, `tcnt` cleared.
  - DATA: every OVERSAMPLE ticks, shift `rxs` into `shreg[7]` (LSB first). The 3-bit `bitcnt` increments; after bit 7 -> STOP.
  - STOP: after OVERSAMPLE ticks, sample `rxs`. If 1, deliver the byte -> IDLE. If 0, pulse `frame_err`, discard the byte -> BREAK.
  - BREAK: wait for `rxs==1` -> IDLE. This absorbs line breaks without generating spurious frames.
- **Output register on delivery:**
  - If `rx_valid==0`, or a handshake occurs in the same cycle: load `rx_data`, set `rx_valid=1`.
  - Otherwise: keep the old byte, pulse `overrun`, drop the new byte.
- **Handshake without delivery:** `rx_valid` clears the cycle after the transfer; `rx_data` keeps its last value.
- **Reset values (`rst_n==0`):**
  - State IDLE; `tcnt`, `bitcnt`, `shreg` = 0.
  - Sync flops = 1.
  - `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - Reset mid-frame abandons the frame with no error pulse.

## Timing

- Input sync latency: 2 cycles, `rx` to `rxs`.
- IDLE -> START: the cycle after `rxs` falls.
- Delivery: `rx_valid` rises 1 cycle after the STOP sample tick. That is about 9.5 bit times after the start edge plus 3 cycles.
- `frame_err` and `overrun` are registered single-cycle pulses, aligned with the cycle `rx_valid` would have risen.
- A new start bit is accepted the cycle after returning to IDLE. Back-to-back frames with a 1-bit stop are sustained.
- Sampling error budget: ±1/OVERSAMPLE bit from tick quantization plus the tick generator's ±2% over a byte.

## Structure

- Package `uart_pkg`:
  - `uart_rx_state_t` enum (IDLE, START, DATA, STOP, BREAK).
  - `localparam DATA_BITS = 8`.
  - Shared with the future `uart_tx`.
- One sub-module: `baud_tick_gen`, instantiated with `clk_freq=CLK_FREQ`, `baud=BAUD`, `oversampling=OVERSAMPLE`, `enable=tick_en`.
- The synchronizer, FSM and output register are inline.

## Test plan

All at 12 MHz / 115200 / 8x, about 104.2 clk per bit.

1. Send 0x55, stop=1, `rx_ready=1`. `rx_valid` goes high for 1 cycle, `rx_data=0x55`, about 990 clk after the falling edge. No error pulses.
2. Pull `rx` low for 20 clk, then high. No `rx_valid`, no `frame_err`; FSM back in IDLE within 1 bit time.
3. Send 0xA3 with stop=0, then hold low 2000 clk, then release. One `frame_err` pulse, no `rx_valid`, FSM in BREAK until release. A following 0x3C is received correctly.
4. `rx_ready=0`; send 0x11 then 0x22. `rx_data` stays 0x11; one `overrun` pulse at the second stop sample. Raising `rx_ready` completes one transfer and `rx_valid` falls.
5. Back-to-back 0x00, 0xFF, 0x81, `rx_ready=1`. Three deliveries in order, no errors.
6. Assert `rst_n=0` for 1 cycle mid-DATA of 0x77. All outputs read 0, no error pulse. Next frame 0x5A is delivered correctly.
